// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter.
// Serializes one key event as the byte sequence [E0] [F0] code, each byte as
// an 11-bit PS/2 frame (start 0, 8 data LSB first, odd parity, stop 1).
// The block backs off while the host inhibits the clock line and restarts
// the byte from its start bit.
//
// Ports:
//   clk_sys       system clock, all logic on the rising edge
//   reset         synchronous, active-high
//   ev_valid      key event offered
//   ev_ready      event accepted this cycle (high only in IDLE)
//   ev_pressed    1 = make, 0 = break (adds F0 prefix)
//   ev_extended   1 = adds E0 prefix
//   ev_code       8-bit scan code
//   ps2_clk_in    sampled PS/2 clock line (asynchronous)
//   ps2_clk_out   1 = release clock line, 0 = drive low
//   ps2_data_out  1 = release data line, 0 = drive low
//   busy          high from acceptance until the last byte's gap completes
//   byte_done     one-cycle pulse as each byte's gap begins
module ps2_kbd_tx #(
   parameter int unsigned HALF_PERIOD = 960,
   parameter int unsigned GAP_HALVES  = 2
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic       ev_pressed,
   input  logic       ev_extended,
   input  logic [7:0] ev_code,
   input  logic       ps2_clk_in,
   output logic       ps2_clk_out,
   output logic       ps2_data_out,
   output logic       busy,
   output logic       byte_done
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned GAP_W = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
   localparam logic [CNT_W-1:0] HALF_LOAD   = CNT_W'(HALF_PERIOD - 1);
   // Inhibit is only honoured once 3 cycles of the high phase have elapsed,
   // covering synchronizer latency after this block releases the clock.
   localparam logic [CNT_W-1:0] INHIBIT_MAX = CNT_W'(HALF_PERIOD - 4);
   localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_HALVES - 1);
   localparam logic [3:0]       BIT_STOP    = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LINE,
      S_BIT_HI,
      S_BIT_LO,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             ext_q, ext_d;
   logic             brk_q, brk_d;
   logic [7:0]       code_q, code_d;
   logic             clk_q, clk_d;
   logic             data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [1:0]       sync_q;
   logic             clk_s;
   logic [7:0]       cur_byte;

   // Line level for frame position idx of byte d.
   function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d);
      logic b;
      case (idx)
         4'd0:    b = 1'b0;
         4'd9:    b = ~(^d);
         4'd10:   b = 1'b1;
         default: b = d[3'(idx - 4'd1)];
      endcase
      return b;
   endfunction

   assign clk_s    = sync_q[1];
   // Pending prefixes go out first; the code byte is last.
   assign cur_byte = ext_q ? 8'hE0 : (brk_q ? 8'hF0 : code_q);

   assign ev_ready     = (state_q == S_IDLE);
   assign ps2_clk_out  = clk_q;
   assign ps2_data_out = data_q;
   assign busy         = busy_q;
   assign byte_done    = done_q;

   // State and output registers, plus the clock-line synchronizer.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         code_q  <= '0;
         clk_q   <= 1'b1;
         data_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         ext_q   <= ext_d;
         brk_q   <= brk_d;
         code_q  <= code_d;
         clk_q   <= clk_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sync_q  <= {sync_q[0], ps2_clk_in};
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      ext_d   = ext_q;
      brk_d   = brk_q;
      code_d  = code_q;
      clk_d   = clk_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            clk_d  = 1'b1;
            data_d = 1'b1;
            busy_d = 1'b0;
            if (ev_valid) begin
               ext_d   = ev_extended;
               brk_d   = ~ev_pressed;
               code_d  = ev_code;
               bit_d   = '0;
               busy_d  = 1'b1;
               state_d = S_WAIT_LINE;
            end
         end

         S_WAIT_LINE: begin
            clk_d  = 1'b1;
            data_d = 1'b1;
            if (clk_s) begin
               cnt_d   = HALF_LOAD;
               data_d  = frame_bit(bit_q, cur_byte);
               state_d = S_BIT_HI;
            end
         end

         S_BIT_HI: begin
            if (!clk_s && (cnt_q <= INHIBIT_MAX)) begin
               // Host inhibit: drop this attempt and resend the byte later.
               clk_d   = 1'b1;
               data_d  = 1'b1;
               bit_d   = '0;
               state_d = S_WAIT_LINE;
            end else if (cnt_q == '0) begin
               cnt_d   = HALF_LOAD;
               clk_d   = 1'b0;
               state_d = S_BIT_LO;
            end
         end

         S_BIT_LO: begin
            if (cnt_q == '0) begin
               cnt_d = HALF_LOAD;
               clk_d = 1'b1;
               if (bit_q == BIT_STOP) begin
                  data_d  = 1'b1;
                  gap_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_GAP;
               end else begin
                  bit_d   = bit_q + 4'd1;
                  data_d  = frame_bit(bit_q + 4'd1, cur_byte);
                  state_d = S_BIT_HI;
               end
            end
         end

         S_GAP: begin
            clk_d  = 1'b1;
            data_d = 1'b1;
            if (cnt_q == '0) begin
               if (gap_q == GAP_LAST) begin
                  if (ext_q || brk_q) begin
                     if (ext_q) begin
                        ext_d = 1'b0;
                     end else begin
                        brk_d = 1'b0;
                     end
                     bit_d   = '0;
                     state_d = S_WAIT_LINE;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end
               end else begin
                  gap_d = gap_q + GAP_W'(1);
                  cnt_d = HALF_LOAD;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: self-checking bench for ps2_kbd_tx.
// A line monitor decodes frames off the PS/2 outputs; a reference model turns
// each accepted event into its expected frame list and cycle budget.
module tb_ps2_kbd_tx;

   localparam int HP   = 4;
   localparam int GAPH = 2;
   // One byte: a cycle waiting for the line, 22 half-periods, then the gap.
   localparam int BYTE_CYC = 1 + 22 * HP + GAPH * HP;

   logic       clk_sys;
   logic       reset;
   logic       ev_valid;
   logic       ev_ready;
   logic       ev_pressed;
   logic       ev_extended;
   logic [7:0] ev_code;
   logic       ps2_clk_in;
   logic       ps2_clk_out;
   logic       ps2_data_out;
   logic       busy;
   logic       byte_done;
   logic       host_clk;

   // Open-collector clock line shared with a host that may pull it low.
   assign ps2_clk_in = ps2_clk_out & host_clk;

   ps2_kbd_tx #(.HALF_PERIOD(HP), .GAP_HALVES(GAPH)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_pressed   (ev_pressed),
      .ev_extended  (ev_extended),
      .ev_code      (ev_code),
      .ps2_clk_in   (ps2_clk_in),
      .ps2_clk_out  (ps2_clk_out),
      .ps2_data_out (ps2_data_out),
      .busy         (busy),
      .byte_done    (byte_done)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   initial forever begin
      @(posedge clk_sys);
      cyc++;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   // Line monitor
   logic [10:0] rx_q[$];
   logic [10:0] exp_q[$];
   int          gap_q[$];
   logic [10:0] mon_shift = '0;
   int mon_bits = 0, mon_falls = 0, mon_done = 0, mon_abort = 0, mon_viol = 0;
   int hi_run = 0, done_cyc = 0;
   bit have_done = 0;
   logic prev_clk = 1'b1, prev_data = 1'b1;

   initial forever begin
      @(negedge clk_sys);
      if (reset) begin
         mon_bits  = 0;
         hi_run    = 0;
         have_done = 0;
      end else begin
         if (byte_done) begin
            mon_done++;
            done_cyc  = cyc;
            have_done = 1;
         end
         if (!busy) have_done = 0;
         if (!ps2_data_out && prev_data && ps2_clk_out && mon_bits == 0 && have_done) begin
            gap_q.push_back(cyc - done_cyc);
            have_done = 0;
         end
         if (prev_clk && !ps2_clk_out) begin
            mon_falls++;
            mon_shift = {ps2_data_out, mon_shift[10:1]};
            mon_bits++;
            hi_run = 0;
            if (mon_bits == 11) begin
               rx_q.push_back(mon_shift);
               mon_bits = 0;
            end
         end else if (ps2_clk_out) begin
            hi_run++;
            // A clock high far longer than a half-period means the frame was abandoned.
            if (hi_run > HP + 2 && mon_bits != 0) begin
               mon_bits = 0;
               mon_abort++;
            end
         end
         if (!ps2_clk_out && !prev_clk && ps2_data_out != prev_data) mon_viol++;
         if (ev_ready == busy) mon_viol++;
      end
      prev_clk  = ps2_clk_out;
      prev_data = ps2_data_out;
   end

   // Reference model: PS/2 frame of one byte, bit i transmitted i-th.
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      logic par;
      par = ($countones(b) % 2 == 0);
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic tick();
      @(negedge clk_sys);
      #1;
   endtask

   // Offer an event and hold it until accepted; acc is the accepting edge number.
   task automatic offer(input logic p, input logic e, input logic [7:0] c,
                        input bit keep, output int acc);
      bit got;
      got         = 0;
      acc         = -1;
      ev_pressed  = p;
      ev_extended = e;
      ev_code     = c;
      ev_valid    = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         if (ev_ready) begin
            acc = cyc + 1;
            got = 1;
            tick();
            break;
         end
         tick();
      end
      if (!keep) ev_valid = 1'b0;
      check("accept_in_time", int'(got), 1);
      if (e) exp_q.push_back(frame_of(8'hE0));
      if (!p) exp_q.push_back(frame_of(8'hF0));
      exp_q.push_back(frame_of(c));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20000 && !(ev_ready && !busy); i++) tick();
      check("idle_reached", int'(ev_ready && !busy), 1);
   endtask

   task automatic compare_rx(input string tag);
      check({tag, "_frame_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         check({tag, "_frame"}, int'(rx_q[i]), int'(exp_q[i]));
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int acc, prev_acc, prev_n, f0, d0, a0, rel, nbytes, bad;
      logic p, e;
      logic [7:0] c;
      logic [10:0] spec_29;

      reset       = 1'b1;
      ev_valid    = 1'b0;
      ev_pressed  = 1'b0;
      ev_extended = 1'b0;
      ev_code     = 8'h00;
      host_clk    = 1'b1;
      spec_29     = 11'b10001010010;
      repeat (3) tick();

      // Reset values
      check("rst_clk_out", int'(ps2_clk_out), 1);
      check("rst_data_out", int'(ps2_data_out), 1);
      check("rst_ev_ready", int'(ev_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_byte_done", int'(byte_done), 0);
      reset = 1'b0;
      repeat (2) tick();

      // Make 0x29, line high
      f0 = mon_falls; d0 = mon_done;
      offer(1'b1, 1'b0, 8'h29, 1'b0, acc);
      check("make29_busy_c1", int'(busy), 1);
      check("make29_ready_c1", int'(ev_ready), 0);
      tick();
      check("make29_start_c2", int'(ps2_data_out), 0);
      check("make29_clk_c2", int'(ps2_clk_out), 1);
      for (int i = 0; i < 100 && ps2_clk_out; i++) tick();
      check("make29_first_fall", cyc - acc, HP + 1);
      wait_idle();
      check("make29_ready_low_cycles", cyc - acc, BYTE_CYC);
      check("make29_falls", mon_falls - f0, 11);
      check("make29_byte_done", mon_done - d0, 1);
      if (rx_q.size() > 0) check("make29_bits", int'(rx_q[0]), int'(spec_29));
      compare_rx("make29");

      // Break extended 0x75
      d0 = mon_done; gap_q.delete();
      offer(1'b0, 1'b1, 8'h75, 1'b0, acc);
      wait_idle();
      check("brk75_byte_done", mon_done - d0, 3);
      check("brk75_gap_count", gap_q.size(), 2);
      foreach (gap_q[i]) check("brk75_gap_len", gap_q[i], GAPH * HP + 1);
      if (rx_q.size() == 3) begin
         check("brk75_par_e0", int'(rx_q[0][9]), 0);
         check("brk75_par_f0", int'(rx_q[1][9]), 1);
         check("brk75_par_75", int'(rx_q[2][9]), 0);
      end
      compare_rx("brk75");
      repeat (5) tick();

      // Inhibit before start
      host_clk = 1'b0;
      repeat (50) tick();
      f0 = mon_falls;
      offer(1'b1, 1'b0, 8'h1C, 1'b0, acc);
      repeat (50) tick();
      check("inh_pre_no_edges", mon_falls - f0, 0);
      check("inh_pre_data_released", int'(ps2_data_out), 1);
      check("inh_pre_busy", int'(busy), 1);
      host_clk = 1'b1;
      rel = cyc;
      for (int i = 0; i < 50 && ps2_data_out; i++) tick();
      check("inh_pre_start_delay", cyc - rel, 3);
      wait_idle();
      compare_rx("inh_pre");

      // Inhibit mid-frame during bit 5 of F0
      d0 = mon_done; a0 = mon_abort;
      offer(1'b1 ^ 1'b1, 1'b0, 8'h5A, 1'b0, acc);
      for (int i = 0; i < 500 && !(mon_bits == 5 && ps2_clk_out && rx_q.size() == 0); i++) tick();
      check("inh_mid_reached_bit5", int'(mon_bits == 5 && ps2_clk_out), 1);
      host_clk = 1'b0;
      f0 = mon_falls;
      repeat (20) tick();
      check("inh_mid_no_edges", mon_falls - f0, 0);
      check("inh_mid_no_byte_done", mon_done - d0, 0);
      check("inh_mid_clk_released", int'(ps2_clk_out), 1);
      check("inh_mid_data_released", int'(ps2_data_out), 1);
      host_clk = 1'b1;
      wait_idle();
      check("inh_mid_aborts", mon_abort - a0, 1);
      check("inh_mid_byte_done", mon_done - d0, 2);
      compare_rx("inh_mid");

      // Reset during bit 3
      offer(1'b1, 1'b0, 8'h33, 1'b0, acc);
      for (int i = 0; i < 500 && !(mon_bits == 3 && ps2_clk_out); i++) tick();
      reset = 1'b1;
      tick();
      check("rst_mid_clk_out", int'(ps2_clk_out), 1);
      check("rst_mid_data_out", int'(ps2_data_out), 1);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_ev_ready", int'(ev_ready), 1);
      reset = 1'b0;
      f0 = mon_falls; d0 = mon_done;
      repeat (60) tick();
      check("rst_mid_no_edges", mon_falls - f0, 0);
      check("rst_mid_no_byte_done", mon_done - d0, 0);
      check("rst_mid_no_frames", rx_q.size(), 0);
      rx_q.delete();
      exp_q.delete();

      // Back-to-back: two fixed events then random ones, ev_valid held throughout
      d0 = mon_done; gap_q.delete();
      prev_acc = 0; prev_n = 0; nbytes = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) begin p = 1'b1; e = 1'b1; c = 8'h6B; end
         else if (k == 1) begin p = 1'b0; e = 1'b0; c = 8'h12; end
         else begin
            p = 1'($urandom_range(0, 1));
            e = 1'($urandom_range(0, 1));
            c = 8'($urandom_range(0, 255));
         end
         offer(p, e, c, k < 9, acc);
         if (k > 0) check("b2b_accept_spacing", acc - prev_acc, BYTE_CYC * prev_n + 1);
         prev_acc = acc;
         prev_n   = 1 + int'(e) + int'(!p);
         nbytes  += prev_n;
      end
      wait_idle();
      check("b2b_byte_done", mon_done - d0, nbytes);
      bad = 0;
      foreach (gap_q[i]) if (gap_q[i] != GAPH * HP + 1) bad++;
      check("b2b_gap_len_bad", bad, 0);
      compare_rx("b2b");

      check("ready_busy_data_rules", mon_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Device-side PS/2 keyboard transmitter. It serializes key events onto PS/2 clock and data lines as standard 11-bit frames. Each event carries press/release, an extended flag and an 8-bit scan code, and is emitted as the byte sequence [E0] [F0] code. This is the producing end of the keyboard path whose events the core's scan-code decoder consumes (E0 extended prefix, F0 break prefix). The block drives an external PS/2 port or a loopback into the core's PS/2 receiver during bring-up and key-replay tests.

## Interface
- HALF_PERIOD, 960: clk_sys cycles per PS/2 clock half-period (40 us at 24 MHz, 12.5 kHz line clock); legal range 4..65535.
- GAP_HALVES, 2: idle half-periods with both lines released between consecutive bytes.

- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ev_valid  in  1  key event offered.
- ev_ready  out  1  block accepts an event this cycle; transfer occurs when ev_valid & ev_ready.
- ev_pressed  in  1  1 = make, 0 = break (F0 prefix).
- ev_extended  in  1  1 = E0 prefix.
- ev_code  in  8  scan code.
- ps2_clk_in  in  1  sampled PS/2 clock line, asynchronous; used for host-inhibit detect.
- ps2_clk_out  out  1  1 = release line, 0 = drive low.
- ps2_data_out  out  1  1 = release line, 0 = drive low.
- busy  out  1  high from acceptance until the last byte's gap completes.
- byte_done  out  1  one-cycle pulse after each byte's stop bit completes.

## Operation
- ps2_clk_in passes through a 2-FF synchronizer (clk_s) before any use.
- Acceptance: ev_ready = 1 only in IDLE. On transfer, latch the event and build the byte list: E0 if extended, F0 if !pressed, then the code. The list holds 1–3 bytes.
- Frame format: start 0, data[0]..data[7] LSB first, odd parity (XOR of data, inverted), stop 1.
- States:
  - IDLE
  - WAIT_LINE: hold while clk_s = 0 (host inhibit); advance when clk_s = 1.
  - BIT_HI: ps2_clk_out = 1, ps2_data_out = current bit, for HALF_PERIOD cycles.
  - BIT_LO: ps2_clk_out = 0 for HALF_PERIOD cycles.
  - GAP: both outputs 1, for GAP_HALVES × HALF_PERIOD cycles.
- Bit sequencing: after BIT_LO ends, increment the bit index 0..10 and enter BIT_HI. After BIT_LO of bit 10, pulse byte_done and enter GAP.
- After GAP, enter WAIT_LINE if bytes remain, otherwise IDLE.
- Host inhibit mid-frame: if clk_s = 0 in BIT_HI after the first 3 cycles of that phase (3 cycles cover synchronizer latency after this block's own release), abort.
  - Release both lines and enter WAIT_LINE.
  - Reset the bit index to 0 and retransmit the same byte from the start bit.
  - No byte_done for the aborted byte.
- clk_s is ignored during BIT_LO (this block is driving the line low).
- Half-period counter is 16 bits, loaded with HALF_PERIOD-1 on every phase entry, and counts down to 0. No wrap beyond 0.
- reset at any time forces IDLE on the next edge: lines released, byte list cleared, counters zeroed. A partial frame is dropped, not resumed.

## Timing
- Reset values: ps2_clk_out = 1, ps2_data_out = 1, ev_ready = 1, busy = 0, byte_done = 0.
- All outputs are registered except ev_ready = (state == IDLE).
- Event accepted at cycle 0:
  - busy = 1 and state = WAIT_LINE at cycle 1.
  - With the line high, BIT_HI is entered at cycle 2 and ps2_data_out = 0 (start bit) at cycle 2.
  - First ps2_clk_out falling edge at cycle 2 + HALF_PERIOD.
- Byte duration: 22 × HALF_PERIOD cycles, then GAP.
- byte_done is asserted on the cycle GAP is entered.
- busy falls, and ev_ready rises, on the cycle after the final GAP ends.
- Data changes only on entry to BIT_HI, i.e. while ps2_clk_out = 1.
- ev_valid during busy is not accepted and is not lost: the source holds it.

## Test plan
- HALF_PERIOD = 4, make 0x29, line high:
  - Data bits observed at clock falling edges are 0, 1,0,0,1,0,1,0,0, parity 0, stop 1.
  - 11 falling edges; byte_done once.
  - ev_ready returns 97 cycles after acceptance (1 + 88 + 8).
- Break extended 0x75:
  - Three frames E0 (parity 0), F0 (parity 1), 75 (parity 0).
  - Three byte_done pulses; 8-cycle released gap between frames.
- Inhibit before start: hold ps2_clk_in = 0 for 50 cycles, then offer an event.
  - No clock edges while held.
  - Start bit appears 3 cycles after release (2 synchronizer + 1).
- Inhibit mid-frame: pull ps2_clk_in low during BIT_HI of bit 5 of F0.
  - Lines released and no byte_done.
  - After release, F0 is fully retransmitted, then the code byte.
- Reset asserted during bit 3: next cycle ps2_clk_out = 1, ps2_data_out = 1, busy = 0, ev_ready = 1; no further edges.
- Back-to-back: ev_valid held with two events.
  - Second accepted only after the first's gap.
  - No frame overlap; ev_ready low throughout busy.
